// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Fetch sequencer for a synchronous-read, byte-addressable instruction memory.
// Owns the fetch PC, issues at most one word read per cycle, tracks the single
// read in flight across the memory's 1-cycle latency and buffers returned
// words in a 2-entry skid FIFO whose head register drives the IF/ID outputs.
// Handles decode back-pressure, control-flow redirects and illegal targets.
//
// Ports:
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   mem_addr, mem_en     read request to instruction memory (addr = fetch PC)
//   mem_rdata            read data, valid the cycle after mem_en
//   stall                decode not ready; if_* hold while high
//   redirect_valid/_pc   restart fetch at redirect_pc (highest priority)
//   if_valid/instr/pc    head of the skid FIFO toward decode
//   fault, fault_pc      sticky illegal-target indication and its address
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] mem_addr,
  output logic        mem_en,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFault = 2'd2;

  localparam logic [32:0] LastByte = 33'(MEM_BYTES) - 33'd1;

  // 33-bit sum so targets near 2^32 cannot wrap into the legal range.
  function automatic logic pc_legal(input logic [31:0] pc);
    logic [32:0] last;
    last = {1'b0, pc} + 33'd3;
    return (pc[1:0] == 2'b00) && (last <= LastByte);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_epoch_q, rsp_epoch_d;
  logic        epoch_q, epoch_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic       pop;
  logic       cur_legal;
  logic [2:0] occ;
  logic       credit_ok;
  logic       issue;
  logic       fault_now;
  logic       flush;
  logic       rsp_write;
  logic [1:0] wr_slot;

  always_comb begin
    pop       = (count_q != 2'd0) && !stall;
    cur_legal = pc_legal(fetch_pc_q);
    // Slots already committed (buffered + in flight) after this cycle's pop.
    occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    credit_ok = occ < 3'd2;
    issue     = (state_q == StRun) && cur_legal && !redirect_valid && credit_ok;
    fault_now = (state_q == StRun) && !cur_legal && !redirect_valid;
    flush     = redirect_valid || fault_now;
    // Stale-epoch responses belong to a fetch stream that was already flushed.
    rsp_write = inflight_q && (rsp_epoch_q == epoch_q) && !flush && (state_q == StRun);
    wr_slot   = count_q - {1'b0, pop};
  end

  // Control: state, fetch PC, fault and in-flight tracking.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    fault_d     = fault_q;
    fault_pc_d  = fault_pc_q;
    inflight_d  = issue;
    rsp_pc_d    = issue ? fetch_pc_q : rsp_pc_q;
    rsp_epoch_d = issue ? epoch_q : rsp_epoch_q;
    epoch_d     = flush ? ~epoch_q : epoch_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      if (pc_legal(redirect_pc)) begin
        state_d = StRun;
        fault_d = 1'b0;
      end else begin
        state_d    = StFault;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StRun;
        StRun: begin
          if (!cur_legal) begin
            state_d    = StFault;
            fault_d    = 1'b1;
            fault_pc_d = fetch_pc_q;
          end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        default: state_d = StFault;
      endcase
    end
  end

  // Skid FIFO: head register feeds decode, tail holds the second word.
  always_comb begin
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && (count_q == 2'd2)) begin
        head_pc_d    = tail_pc_q;
        head_instr_d = tail_instr_q;
      end
      if (rsp_write) begin
        if (wr_slot == 2'd0) begin
          head_pc_d    = rsp_pc_q;
          head_instr_d = mem_rdata;
        end else begin
          tail_pc_d    = rsp_pc_q;
          tail_instr_d = mem_rdata;
        end
      end
      count_d = count_q - {1'b0, pop} + {1'b0, rsp_write};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      inflight_q   <= 1'b0;
      rsp_pc_q     <= 32'h0;
      rsp_epoch_q  <= 1'b0;
      epoch_q      <= 1'b0;
      count_q      <= 2'd0;
      head_pc_q    <= 32'h0;
      head_instr_q <= 32'h0;
      tail_pc_q    <= 32'h0;
      tail_instr_q <= 32'h0;
      fault_q      <= 1'b0;
      fault_pc_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= inflight_d;
      rsp_pc_q     <= rsp_pc_d;
      rsp_epoch_q  <= rsp_epoch_d;
      epoch_q      <= epoch_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
      fault_q      <= fault_d;
      fault_pc_q   <= fault_pc_d;
    end
  end

  assign mem_en   = issue;
  assign mem_addr = fetch_pc_q;
  assign if_valid = (count_q != 2'd0);
  assign if_instr = head_instr_q;
  assign if_pc    = head_pc_q;
  assign fault    = fault_q;
  assign fault_pc = fault_pc_q;

endmodule
